// File: rtl/hci_cmd_executor.sv
`default_nettype none
// ============================================================================
// Module      : hci_cmd_executor
// Description : Executes one write command at a time, streaming TX-queue bytes
//               to the bus engine and posting a single response word.
// Revision    : 1.0 - initial release
// ============================================================================
module hci_cmd_executor #(
    parameter int DataLenW = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        cmd_rvalid_i,
    output logic        cmd_rready_o,
    input  logic [63:0] cmd_rdata_i,

    input  logic        tx_rvalid_i,
    output logic        tx_rready_o,
    input  logic [31:0] tx_rdata_i,

    output logic        resp_wvalid_o,
    input  logic        resp_wready_i,
    output logic [31:0] resp_wdata_o,

    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic [7:0]  byte_data_o,
    output logic        byte_last_o,

    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] c_ERR_UNSUPPORTED = 4'h9;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_tid;
    logic [3:0]           r_err;
    logic [15:0]          r_resp_len;
    logic [DataLenW-1:0]  r_remaining;
    logic [31:0]          r_word;
    logic [1:0]           r_idx;

    logic [2:0]           w_cmd_attr;
    logic [3:0]           w_cmd_tid;
    logic                 w_cmd_rnw;
    logic [15:0]          w_cmd_len;
    logic                 w_cmd_bad;
    logic                 w_cmd_xfer;
    logic                 w_tx_xfer;
    logic                 w_byte_xfer;
    logic                 w_resp_xfer;
    logic                 w_last_byte;
    logic                 w_unused_cmd_bits;

    assign w_cmd_attr        = cmd_rdata_i[2:0];
    assign w_cmd_tid         = cmd_rdata_i[6:3];
    assign w_cmd_rnw         = cmd_rdata_i[29];
    assign w_cmd_len         = cmd_rdata_i[63:48];
    assign w_cmd_bad         = (w_cmd_attr != 3'h0) || w_cmd_rnw;
    assign w_unused_cmd_bits = ^{cmd_rdata_i[47:30], cmd_rdata_i[28:7]};

    assign w_cmd_xfer  = cmd_rvalid_i  & cmd_rready_o;
    assign w_tx_xfer   = tx_rvalid_i   & tx_rready_o;
    assign w_byte_xfer = byte_valid_o  & byte_ready_i;
    assign w_resp_xfer = resp_wvalid_o & resp_wready_i;
    assign w_last_byte = (r_remaining == DataLenW'(1));

    always_comb begin
        w_state_nxt   = r_state;
        cmd_rready_o  = 1'b0;
        tx_rready_o   = 1'b0;
        byte_valid_o  = 1'b0;
        byte_data_o   = 8'h00;
        byte_last_o   = 1'b0;
        resp_wvalid_o = 1'b0;
        resp_wdata_o  = 32'h0000_0000;
        busy_o        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                cmd_rready_o = 1'b1;
                if (w_cmd_xfer) begin
                    if (w_cmd_bad || (w_cmd_len == 16'h0000)) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                tx_rready_o = 1'b1;
                if (w_tx_xfer) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                byte_valid_o = 1'b1;
                byte_data_o  = r_word[{r_idx, 3'b000} +: 8];
                byte_last_o  = w_last_byte;
                if (w_byte_xfer) begin
                    if (w_last_byte) begin
                        w_state_nxt = RESP;
                    end else if (r_idx == 2'd3) begin
                        w_state_nxt = FETCH;
                    end
                end
            end
            RESP: begin
                resp_wvalid_o = 1'b1;
                resp_wdata_o  = {r_err, r_tid, 8'h00, r_resp_len};
                if (w_resp_xfer) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_tid       <= 4'h0;
            r_err       <= 4'h0;
            r_resp_len  <= 16'h0000;
            r_remaining <= '0;
            r_word      <= 32'h0000_0000;
            r_idx       <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_cmd_xfer) begin
                        r_tid       <= w_cmd_tid;
                        r_remaining <= DataLenW'(w_cmd_len);
                        r_err       <= w_cmd_bad ? c_ERR_UNSUPPORTED : 4'h0;
                        r_resp_len  <= w_cmd_bad ? 16'h0000 : w_cmd_len;
                    end
                end
                FETCH: begin
                    if (w_tx_xfer) begin
                        r_word <= tx_rdata_i;
                        r_idx  <= 2'd0;
                    end
                end
                SEND: begin
                    // idx wraps 3->0 naturally; FETCH reloads it anyway
                    if (w_byte_xfer) begin
                        r_remaining <= r_remaining - DataLenW'(1);
                        r_idx       <= r_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hci_cmd_executor.sv
`default_nettype none
// ============================================================================
// Module      : tb_hci_cmd_executor
// Description : Directed vector bench for hci_cmd_executor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hci_cmd_executor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_rvalid_i;
    logic        cmd_rready_o;
    logic [63:0] cmd_rdata_i;
    logic        tx_rvalid_i;
    logic        tx_rready_o;
    logic [31:0] tx_rdata_i;
    logic        resp_wvalid_o;
    logic        resp_wready_i;
    logic [31:0] resp_wdata_o;
    logic        byte_valid_o;
    logic        byte_ready_i;
    logic [7:0]  byte_data_o;
    logic        byte_last_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    hci_cmd_executor #(.DataLenW(16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cmd_rvalid_i  (cmd_rvalid_i),
        .cmd_rready_o  (cmd_rready_o),
        .cmd_rdata_i   (cmd_rdata_i),
        .tx_rvalid_i   (tx_rvalid_i),
        .tx_rready_o   (tx_rready_o),
        .tx_rdata_i    (tx_rdata_i),
        .resp_wvalid_o (resp_wvalid_o),
        .resp_wready_i (resp_wready_i),
        .resp_wdata_o  (resp_wdata_o),
        .byte_valid_o  (byte_valid_o),
        .byte_ready_i  (byte_ready_i),
        .byte_data_o   (byte_data_o),
        .byte_last_o   (byte_last_o),
        .busy_o        (busy_o)
    );

    typedef struct {
        logic [2:0]  attr;
        logic        rnw;
        logic [3:0]  tid;
        logic [15:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          tx_delay;
        bit          toggle;
        int          resp_delay;
        int          nbytes;
        logic [63:0] exp_bytes;
        int          exp_pops;
        logic [31:0] exp_resp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_cmd(input vec_t v);
        logic [63:0] c;
        c        = 64'h0;
        c[2:0]   = v.attr;
        c[6:3]   = v.tid;
        c[29]    = v.rnw;
        c[63:48] = v.len;
        return c;
    endfunction

    task automatic idle_inputs();
        cmd_rvalid_i  = 1'b0;
        cmd_rdata_i   = 64'h0;
        tx_rvalid_i   = 1'b0;
        tx_rdata_i    = 32'h0;
        resp_wready_i = 1'b0;
        byte_ready_i  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm, input bit b2b);
        logic [31:0] words [3];
        logic [31:0] resp;
        int  pops, nb, acc_cyc, first_bv, last_acc, resp_vis, rv_cnt, cyc;
        bit  sent, done, busy_ok;
        words    = '{v.w0, v.w1, v.w2};
        resp     = 32'h0;
        pops = 0; nb = 0; acc_cyc = -1; first_bv = -1; last_acc = -1;
        resp_vis = -1; rv_cnt = 0; sent = 0; done = 0; busy_ok = 1;
        for (cyc = 0; cyc < 300 && !done; cyc++) begin
            cmd_rvalid_i  = !sent;
            cmd_rdata_i   = mk_cmd(v);
            tx_rvalid_i   = sent && (cyc > acc_cyc + v.tx_delay) && (pops < 3);
            tx_rdata_i    = (pops < 3) ? words[pops] : 32'h0;
            byte_ready_i  = v.toggle ? (cyc % 2 == 1) : 1'b1;
            resp_wready_i = (rv_cnt >= v.resp_delay);
            #1;
            if (sent && (cmd_rready_o || !busy_o)) busy_ok = 0;
            if (cmd_rvalid_i && cmd_rready_o) begin
                sent    = 1;
                acc_cyc = cyc;
            end
            if (tx_rvalid_i && tx_rready_o) pops++;
            if (byte_valid_o && first_bv < 0) first_bv = cyc;
            if (byte_valid_o && byte_ready_i) begin
                if (nb < 8) begin
                    chk({nm, " byte"}, 64'(byte_data_o), 64'(v.exp_bytes[8*nb +: 8]));
                    chk({nm, " last"}, 64'(byte_last_o), 64'(nb == v.nbytes - 1));
                end
                nb++;
                last_acc = cyc;
            end
            if (resp_wvalid_o) begin
                if (resp_vis < 0) resp_vis = cyc;
                rv_cnt++;
            end
            if (resp_wvalid_o && resp_wready_i) begin
                resp = resp_wdata_o;
                done = 1;
            end
            @(posedge clk_i);
            #1;
        end
        idle_inputs();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no response expected response %0h", nm, v.exp_resp);
        end
        chk({nm, " resp"},   64'(resp), 64'(v.exp_resp));
        chk({nm, " pops"},   64'(pops), 64'(v.exp_pops));
        chk({nm, " nbytes"}, 64'(nb),   64'(v.nbytes));
        chk({nm, " busy/cmd_rready"}, 64'(busy_ok), 64'(1));
        if (v.tx_delay == 0 && v.nbytes > 0)
            chk({nm, " first-byte latency"}, 64'(first_bv - acc_cyc), 64'(2));
        if (v.nbytes > 0)
            chk({nm, " resp latency"}, 64'(resp_vis - last_acc), 64'(1));
        if (b2b)
            chk({nm, " accept cycle"}, 64'(acc_cyc), 64'(0));
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " cmd_rready"},  64'(cmd_rready_o),  64'(1));
        chk({nm, " tx_rready"},   64'(tx_rready_o),   64'(0));
        chk({nm, " resp_wvalid"}, 64'(resp_wvalid_o), 64'(0));
        chk({nm, " byte_valid"},  64'(byte_valid_o),  64'(0));
        chk({nm, " byte_last"},   64'(byte_last_o),   64'(0));
        chk({nm, " byte_data"},   64'(byte_data_o),   64'(0));
        chk({nm, " resp_wdata"},  64'(resp_wdata_o),  64'(0));
        chk({nm, " busy"},        64'(busy_o),        64'(0));
    endtask

    vec_t vecs [7];
    vec_t vrst;
    vec_t vone;

    initial begin
        vecs[0] = '{3'd0, 1'b0, 4'd5,  16'd5, 32'h44332211, 32'h000000AA, 32'h0,
                    0, 1'b0, 0, 5, 64'h000000AA44332211, 2, 32'h05000005};
        vecs[1] = '{3'd0, 1'b0, 4'd3,  16'd0, 32'hDEADBEEF, 32'h0, 32'h0,
                    0, 1'b0, 0, 0, 64'h0, 0, 32'h03000000};
        vecs[2] = '{3'd1, 1'b0, 4'd2,  16'd8, 32'hDEADBEEF, 32'h0, 32'h0,
                    0, 1'b0, 0, 0, 64'h0, 0, 32'h92000000};
        vecs[3] = '{3'd0, 1'b0, 4'd7,  16'd4, 32'hDDCCBBAA, 32'h12345678, 32'h0,
                    3, 1'b1, 0, 4, 64'h00000000DDCCBBAA, 1, 32'h07000004};
        vecs[4] = '{3'd0, 1'b1, 4'd1,  16'd4, 32'hDEADBEEF, 32'h0, 32'h0,
                    0, 1'b0, 0, 0, 64'h0, 0, 32'h91000000};
        vecs[5] = '{3'd0, 1'b0, 4'hF,  16'd6, 32'h04030201, 32'h08070605, 32'h0,
                    0, 1'b0, 5, 6, 64'h0000060504030201, 2, 32'h0F000006};
        vecs[6] = '{3'd0, 1'b0, 4'd9,  16'd8, 32'h44332211, 32'h88776655, 32'hCAFEF00D,
                    0, 1'b0, 0, 8, 64'h8877665544332211, 2, 32'h09000008};
        vone    = '{3'd0, 1'b0, 4'd6,  16'd1, 32'h0000005A, 32'h0, 32'h0,
                    0, 1'b0, 0, 1, 64'h000000000000005A, 1, 32'h06000001};
        vrst    = '{3'd0, 1'b0, 4'd4,  16'd8, 32'h11111111, 32'h22222222, 32'h0,
                    0, 1'b0, 0, 8, 64'h0, 2, 32'h04000008};

        rst_i = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_outputs("in-reset");
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk_reset_outputs("post-reset");

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), i > 0);
        end

        // Abandon a len=8 command after two bytes, then confirm recovery
        begin
            int  nb;
            int  pops;
            bit  sent;
            nb = 0; pops = 0; sent = 0;
            for (int cyc = 0; cyc < 50 && nb < 2; cyc++) begin
                cmd_rvalid_i = !sent;
                cmd_rdata_i  = mk_cmd(vrst);
                tx_rvalid_i  = sent && pops < 2;
                tx_rdata_i   = (pops == 0) ? vrst.w0 : vrst.w1;
                byte_ready_i = 1'b1;
                #1;
                if (cmd_rvalid_i && cmd_rready_o) sent = 1;
                if (tx_rvalid_i && tx_rready_o) pops++;
                if (byte_valid_o && byte_ready_i) nb++;
                @(posedge clk_i);
                #1;
            end
            chk("mid-cmd bytes before reset", 64'(nb), 64'(2));
            chk("mid-cmd pops before reset", 64'(pops), 64'(1));
            idle_inputs();
            rst_i = 1'b1;
            @(posedge clk_i);
            #1;
            rst_i = 1'b0;
            chk_reset_outputs("mid-cmd reset");
        end
        run_vec(vone, "after-reset len1", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hci_cmd_executor.md
HCI_CMD_EXECUTOR -- requirements
Module: hci_cmd_executor

Interface
REQ-001 SHALL have parameter DataLenW, default 16: width of the command data_length field and of the internal byte counter.
REQ-002 SHALL have port clk_i, input, 1: sole clock; every flop SHALL be rising-edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have ports cmd_rvalid_i (in, 1), cmd_rready_o (out, 1), cmd_rdata_i (in, 64): command-queue read side.
REQ-005 SHALL have ports tx_rvalid_i (in, 1), tx_rready_o (out, 1), tx_rdata_i (in, 32): TX-data-queue read side.
REQ-006 SHALL have ports resp_wvalid_o (out, 1), resp_wready_i (in, 1), resp_wdata_o (out, 32): response-queue write side.
REQ-007 SHALL have ports byte_valid_o (out, 1), byte_ready_i (in, 1), byte_data_o (out, 8), byte_last_o (out, 1): byte stream to the bus transfer engine.
REQ-008 SHALL have port busy_o, out, 1: high in every state except IDLE.

Function
REQ-009 Every valid/ready interface SHALL transfer on a cycle where valid and ready are both high; once asserted, an output valid SHALL stay asserted with stable data until it is accepted.
REQ-010 Command fields: cmd_attr=[2:0], tid=[6:3], rnw=[29], data_length=[63:48].
REQ-011 FSM states: IDLE, FETCH, SEND, RESP.
REQ-012 IDLE: cmd_rready_o=1; when a command transfers, the block SHALL latch tid and data_length and assign the state as follows:
- cmd_attr!=3'h0 or rnw=1: err=4'h9, resp_len=0, next state RESP.
- data_length=0 (with attr=0, rnw=0): err=4'h0, resp_len=0, next state RESP.
- otherwise: err=4'h0, resp_len=data_length, next state FETCH.
REQ-013 FETCH: tx_rready_o=1; when a word transfers, the block SHALL latch the word, set byte index to 0 and go to SEND; tx_rready_o SHALL be 0 in every other state.
REQ-014 SEND: byte_data_o SHALL be word[8*idx+7 -: 8] (little-endian: byte 0 = [7:0]); byte_valid_o=1.
REQ-015 Each accepted byte SHALL decrement the remaining-byte counter; byte_last_o SHALL be 1 exactly when the remaining count equals 1.
REQ-016 After an accepted byte in SEND:
- remaining became 0: go to RESP.
- else if idx=3: go to FETCH.
- else: idx+1, stay in SEND.
REQ-017 Unused trailing bytes of the final TX word SHALL be discarded; the number of TX words consumed SHALL equal ceil(data_length/4).
REQ-018 RESP: resp_wvalid_o=1 with resp_wdata_o = {err[31:28], tid[27:24], 8'h00[23:16], resp_len[15:0]}; on acceptance the block SHALL return to IDLE.
REQ-019 cmd_rready_o SHALL be 0 outside IDLE, so at most one command is in flight.
REQ-020 A command SHALL be accepted no earlier than the cycle after the previous response is accepted, giving minimum one idle cycle between commands.
REQ-021 Latency: command accept to first byte_valid_o = 2 cycles when tx_rvalid_i is already high; last byte accept to resp_wvalid_o = 1 cycle.
REQ-022 Back-pressure on byte_ready_i, tx_rvalid_i or resp_wready_i SHALL stall the FSM indefinitely without loss or duplication.
REQ-023 data_length SHALL be treated as unsigned DataLenW bits; 16'hFFFF SHALL be legal and SHALL consume 16384 TX words.

Reset
REQ-024 While rst_i=1 at a clock edge, state SHALL become IDLE and counters, index, err and latched fields SHALL clear.
REQ-025 Output values after reset: cmd_rready_o=1, tx_rready_o=0, resp_wvalid_o=0, byte_valid_o=0, byte_last_o=0, byte_data_o=0, resp_wdata_o=0, busy_o=0.
REQ-026 Reset asserted mid-command SHALL abandon the command with no response, and TX words not yet fetched SHALL remain in the queue.

Verification
REQ-027 Write, tid=5, len=5, TX words 32'h44332211 then 32'h000000AA -> bytes 11,22,33,44,AA with last on AA; 2 TX pops; response 32'h05000005.
REQ-028 Write, len=0, tid=3 -> no TX pop, no bytes; response 32'h03000000.
REQ-029 cmd_attr=3'h1, tid=2, len=8 -> no TX pop, no bytes; response 32'h92000000.
REQ-030 Write len=4 with byte_ready_i toggling every cycle and tx_rvalid_i delayed 3 cycles -> exactly 4 bytes in order, one pop, last on 4th byte.
REQ-031 rst_i pulsed during SEND of a len=8 command -> outputs at REQ-025 values next cycle; a following len=1 command completes normally with response len=1.
REQ-032 Back-to-back commands with resp_wready_i held low for 5 cycles -> cmd_rready_o stays 0 until response accepted; second command accepted in the following IDLE cycle.
